// File: rtl/march_pkg.sv
// Shared definitions for the March C- BIST engine: element table and FSM encoding.
package march_pkg;

  localparam int NUM_ELEM = 6;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // first_wr only matters for single-op elements; two-op elements always read then write.
  typedef struct packed {
    logic       dir;
    logic [1:0] nops;
    logic       first_wr;
    logic       rd_bg;
    logic       wr_bg;
  } elem_cfg_t;

  function automatic elem_cfg_t mk_cfg(input logic d, input logic [1:0] n,
                                       input logic fw, input logic rb, input logic wb);
    mk_cfg = '{dir: d, nops: n, first_wr: fw, rd_bg: rb, wr_bg: wb};
  endfunction

  localparam elem_cfg_t [NUM_ELEM-1:0] ELEM_TBL = {
    mk_cfg(UP,   2'd1, 1'b0, 1'b0, 1'b0),   // M5 up(r0)
    mk_cfg(DOWN, 2'd2, 1'b0, 1'b1, 1'b0),   // M4 down(r1,w0)
    mk_cfg(DOWN, 2'd2, 1'b0, 1'b0, 1'b1),   // M3 down(r0,w1)
    mk_cfg(UP,   2'd2, 1'b0, 1'b1, 1'b0),   // M2 up(r1,w0)
    mk_cfg(UP,   2'd2, 1'b0, 1'b0, 1'b1),   // M1 up(r0,w1)
    mk_cfg(UP,   2'd1, 1'b1, 1'b0, 1'b0)    // M0 up(w0)
  };

endpackage

// File: rtl/march_cmp.sv
// Read-compare pipe: tracks expected data for RD_LAT cycles, counts miscompares
// and latches the first failing address/element/data until the next clear.
module march_cmp
  import march_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        elem_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [7:0]        fail_count_o,
  output logic              pass_nxt_o
);

  logic [RD_LAT-1:0]             vld_pipe;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
  logic [RD_LAT-1:0][2:0]        elem_pipe;

  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [7:0]        fail_cnt_q;
  logic              mis;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe  <= '0;
      exp_pipe  <= '0;
      addr_pipe <= '0;
      elem_pipe <= '0;
    end else begin
      vld_pipe[0]  <= push_i;
      exp_pipe[0]  <= exp_i;
      addr_pipe[0] <= addr_i;
      elem_pipe[0] <= elem_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        exp_pipe[i]  <= exp_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        elem_pipe[i] <= elem_pipe[i-1];
      end
    end
  end

  assign mis = vld_pipe[RD_LAT-1] && (rdata_i != exp_pipe[RD_LAT-1]);

  // A zero count doubles as "no failure captured yet" for the sticky fields.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      fail_cnt_q  <= '0;
    end else if (clr_i) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      fail_cnt_q  <= '0;
    end else if (mis) begin
      if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
      if (fail_cnt_q == 8'd0) begin
        fail_addr_q <= addr_pipe[RD_LAT-1];
        fail_elem_q <= elem_pipe[RD_LAT-1];
        fail_data_q <= rdata_i;
      end
    end
  end

  assign fail_addr_o  = fail_addr_q;
  assign fail_elem_o  = fail_elem_q;
  assign fail_data_o  = fail_data_q;
  assign fail_count_o = fail_cnt_q;
  assign pass_nxt_o   = (fail_cnt_q == 8'd0) && !mis;

endmodule

// File: rtl/march_cminus_ctrl.sv
// March C- sequencer: walks the six elements over the SRAM one op per cycle,
// drives registered SRAM pins and reports Go/NoGo through march_cmp.
module march_cminus_ctrl
  import march_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              GoNoGo,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        fail_count,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gonogo_q, gonogo_d;

  logic              clr, issue, nx_wr, last_phase, last_addr, pass_nxt;

  // elem_q/addr_q/phase_q always describe the op currently on the SRAM pins.
  assign last_phase = (ELEM_TBL[elem_q].nops == 2'd1) || phase_q;
  assign last_addr  = ELEM_TBL[elem_q].dir ? (addr_q == '0) : (addr_q == ADDR_MAX);

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    dcnt_d   = dcnt_q;
    gonogo_d = gonogo_q;
    ce_d     = 1'b0;
    we_d     = 1'b0;
    wdata_d  = '0;
    clr      = 1'b0;
    issue    = 1'b0;
    nx_wr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          issue   = 1'b1;
          state_d = ST_RUN;
          elem_d  = M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (!last_phase) begin
          phase_d = 1'b1;
        end else if (!last_addr) begin
          phase_d = 1'b0;
          addr_d  = ELEM_TBL[elem_q].dir ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end else if (elem_q != M5) begin
          phase_d = 1'b0;
          elem_d  = elem_q + 3'd1;
          addr_d  = ELEM_TBL[elem_d].dir ? ADDR_MAX : '0;
        end else begin
          issue   = 1'b0;
          state_d = ST_DRAIN;
          dcnt_d  = 2'(RD_LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 2'd0) begin
          state_d  = ST_FIN;
          gonogo_d = pass_nxt;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      nx_wr   = (ELEM_TBL[elem_d].nops == 2'd2) ? phase_d : ELEM_TBL[elem_d].first_wr;
      ce_d    = 1'b1;
      we_d    = nx_wr;
      wdata_d = nx_wr ? {DATA_W{ELEM_TBL[elem_d].wr_bg}} : '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      elem_q   <= '0;
      addr_q   <= '0;
      phase_q  <= 1'b0;
      dcnt_q   <= '0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      gonogo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      dcnt_q   <= dcnt_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      gonogo_q <= gonogo_d;
    end
  end

  march_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .clr_i        (clr),
    .push_i       (ce_q & ~we_q),
    .exp_i        ({DATA_W{ELEM_TBL[elem_q].rd_bg}}),
    .addr_i       (addr_q),
    .elem_i       (elem_q),
    .rdata_i      (sram_rdata),
    .fail_addr_o  (fail_addr),
    .fail_elem_o  (fail_elem),
    .fail_data_o  (fail_data),
    .fail_count_o (fail_count),
    .pass_nxt_o   (pass_nxt)
  );

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_FIN);
  assign GoNoGo     = gonogo_q;
  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_march_cminus_ctrl.sv
// Directed bench: behavioural 256x4 SRAM with stuck-at injection, per-op scoreboard
// of the March C- sequence and per-run expected result queue.
module tb_march_cminus_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 4;
  localparam int DEPTH = 256;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, GoNoGo;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
  logic [7:0]    fail_count;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] flt_addr = '0;
  logic [DW-1:0] flt_m0 = '0;
  logic [DW-1:0] flt_m1 = '0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } op_t;

  typedef struct packed {
    logic          go;
    logic [7:0]    cnt;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [DW-1:0] data;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];

  always #5 Clock = ~Clock;

  march_cminus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .GoNoGo     (GoNoGo),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_data  (fail_data),
    .fail_count (fail_count),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Stuck-at faults are applied on the read path of one address.
  always @(posedge Clock) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else if (sram_addr == flt_addr) sram_rdata <= (mem[sram_addr] & ~flt_m0) | flt_m1;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic op_t mk(input logic we, input int a, input logic [DW-1:0] wd);
    mk = '{we: we, addr: a[AW-1:0], wd: wd};
  endfunction

  task automatic push_ops();
    op_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int a;
        a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
        case (e)
          0: op_q.push_back(mk(1'b1, a, 4'h0));
          1: begin op_q.push_back(mk(1'b0, a, 4'h0)); op_q.push_back(mk(1'b1, a, 4'hF)); end
          2: begin op_q.push_back(mk(1'b0, a, 4'h0)); op_q.push_back(mk(1'b1, a, 4'h0)); end
          3: begin op_q.push_back(mk(1'b0, a, 4'h0)); op_q.push_back(mk(1'b1, a, 4'hF)); end
          4: begin op_q.push_back(mk(1'b0, a, 4'h0)); op_q.push_back(mk(1'b1, a, 4'h0)); end
          default: op_q.push_back(mk(1'b0, a, 4'h0));
        endcase
      end
    end
  endtask

  // t counts sampled cycles after acceptance: t=0 is the first op, done expected at t=2561.
  task automatic run_test(input string tag, input int p1, input int p2, input int p3,
                          input int rst_at, input res_t exp);
    int   busy_n, done_t;
    op_t  o;
    res_t r;
    push_ops();
    res_q.push_back(exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":busy_acc"}, 32'(busy), 32'd1);
    chk({tag, ":cnt_clr"}, 32'(fail_count), 32'd0);
    chk({tag, ":fail_clr"}, 32'({fail_addr, fail_elem, fail_data}), 32'd0);
    busy_n = 0;
    done_t = -1;
    for (int t = 0; t < 3000; t++) begin
      if (op_q.size() > 0) begin
        o = op_q.pop_front();
        chk({tag, ":op"}, 32'({sram_ce, sram_we, sram_addr, sram_wdata}), 32'({1'b1, o}));
      end
      if (busy) busy_n++;
      start = (t == p1 || t == p2 || t == p3);
      if (done) begin
        done_t = t;
        break;
      end
      if (t == rst_at) begin
        start = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk({tag, ":rst_ce"}, 32'(sram_ce), 32'd0);
        chk({tag, ":rst_outs"}, 32'({busy, done, GoNoGo}), 32'd0);
        repeat (3) tick();
        chk({tag, ":rst_hold"}, 32'({sram_ce, busy, done}), 32'd0);
        Reset_n = 1'b1;
        op_q.delete();
        res_q.delete();
        tick();
        chk({tag, ":rst_idle"}, 32'({sram_ce, busy}), 32'd0);
        return;
      end
      tick();
    end
    chk({tag, ":ops_left"}, 32'(op_q.size()), 32'd0);
    chk({tag, ":done_cyc"}, 32'(done_t), 32'd2561);
    chk({tag, ":busy_len"}, 32'(busy_n), 32'd2561);
    r = res_q.pop_front();
    chk({tag, ":gonogo"}, 32'(GoNoGo), 32'(r.go));
    chk({tag, ":count"}, 32'(fail_count), 32'(r.cnt));
    chk({tag, ":faddr"}, 32'(fail_addr), 32'(r.addr));
    chk({tag, ":felem"}, 32'(fail_elem), 32'(r.elem));
    chk({tag, ":fdata"}, 32'(fail_data), 32'(r.data));
    tick();
    start = 1'b0;
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    repeat (4) tick();
    chk({tag, ":no_restart"}, 32'({busy, sram_ce}), 32'd0);
    chk({tag, ":gonogo_hold"}, 32'(GoNoGo), 32'(r.go));
  endtask

  initial begin
    res_t pass_r;
    pass_r = '{go: 1'b1, cnt: 8'd0, addr: '0, elem: 3'd0, data: '0};

    repeat (3) tick();
    chk("rst:ctl", 32'({busy, done, GoNoGo}), 32'd0);
    chk("rst:fail", 32'({fail_count, fail_addr, fail_elem, fail_data}), 32'd0);
    chk("rst:sram", 32'({sram_ce, sram_we, sram_addr, sram_wdata}), 32'd0);
    Reset_n = 1'b1;
    tick();

    run_test("clean", -1, -1, -1, -1, pass_r);

    flt_addr = 8'h37; flt_m0 = 4'b0100; flt_m1 = 4'b0000;
    run_test("sa0", -1, -1, -1, -1,
             '{go: 1'b0, cnt: 8'd2, addr: 8'h37, elem: 3'd2, data: 4'b1011});

    flt_addr = 8'hFF; flt_m0 = 4'b0000; flt_m1 = 4'b0001;
    run_test("sa1", -1, -1, -1, -1,
             '{go: 1'b0, cnt: 8'd3, addr: 8'hFF, elem: 3'd1, data: 4'b0001});

    flt_m1 = 4'b0000;
    run_test("busy_start", 99, 2560, 2561, -1, pass_r);
    run_test("mid_reset", -1, -1, -1, 1000, pass_r);
    run_test("after_reset", -1, -1, -1, -1, pass_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
